// File: rtl/sfp_pkg.sv
// rtl/sfp_pkg.sv - shared encodings and lane arithmetic helpers for sfp_multimode
package sfp_pkg;

   localparam logic [2:0] OP_BYPASS = 3'd0;
   localparam logic [2:0] OP_CLEAR  = 3'd1;
   localparam logic [2:0] OP_ACC    = 3'd2;
   localparam logic [2:0] OP_READ   = 3'd3;
   localparam logic [2:0] OP_POOL   = 3'd4;
   localparam logic [2:0] OP_FLUSH  = 3'd5;

   typedef enum logic {POOL_IDLE, POOL_FILL} pool_state_t;

   typedef enum logic [1:0] {SRC_IN, SRC_ACC, SRC_MAX, SRC_POOL} res_src_t;

   // Operands arrive sign-extended to 64 bits so one helper serves any lane width below 64.
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int unsigned w);
      logic signed [63:0] s, hi, lo;
      s  = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi)      return hi;
      else if (s < lo) return lo;
      else             return s;
   endfunction

   function automatic logic signed [63:0] relu(input logic signed [63:0] x);
      return (x < 64'sd0) ? 64'sd0 : x;
   endfunction

endpackage

// File: rtl/sfp_lane.sv
// rtl/sfp_lane.sv - one lane: saturating add, signed max and output ReLU mux
module sfp_lane
   import sfp_pkg::*;
#(
   parameter int psum_bw = 16
) (
   input  logic [psum_bw-1:0] in_val,
   input  logic [psum_bw-1:0] acc_val,
   input  logic [psum_bw-1:0] pool_val,
   input  logic               relu_en,
   input  res_src_t           res_src,
   output logic [psum_bw-1:0] acc_sum,
   output logic [psum_bw-1:0] pool_next,
   output logic [psum_bw-1:0] res
);

   logic signed [63:0] in_x, acc_x, pool_x, sum_x, sel_x, out_x;
   logic               unused_hi;

   assign in_x   = 64'(signed'(in_val));
   assign acc_x  = 64'(signed'(acc_val));
   assign pool_x = 64'(signed'(pool_val));

   assign sum_x   = sat_add(acc_x, in_x, psum_bw);
   assign acc_sum = sum_x[psum_bw-1:0];

   // Strict greater-than so a tie keeps the stored maximum.
   assign pool_next = (in_x > pool_x) ? in_val : pool_val;

   always_comb begin
      sel_x = in_x;
      case (res_src)
         SRC_IN:   sel_x = in_x;
         SRC_ACC:  sel_x = acc_x;
         SRC_MAX:  sel_x = 64'(signed'(pool_next));
         SRC_POOL: sel_x = pool_x;
         default:  sel_x = in_x;
      endcase
   end

   assign out_x = relu_en ? relu(sel_x) : sel_x;
   assign res   = out_x[psum_bw-1:0];

   assign unused_hi = ^{sum_x[63:psum_bw], out_x[63:psum_bw]};

endmodule

// File: rtl/sfp_multimode.sv
// rtl/sfp_multimode.sv - accumulator bank, pool FSM and ready/valid output stage
module sfp_multimode
   import sfp_pkg::*;
#(
   parameter int psum_bw   = 16,
   parameter int col       = 8,
   parameter int acc_depth = 16,
   parameter int pool_max  = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [2:0]                       op,
   input  logic [$clog2(acc_depth)-1:0]     addr,
   input  logic                             relu_en,
   input  logic [$clog2(pool_max+1)-1:0]    pool_win,
   input  logic [psum_bw*col-1:0]           in_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [psum_bw*col-1:0]           out_data,
   output logic                             pool_busy
);

   localparam int aw = $clog2(acc_depth);
   localparam int pw = $clog2(pool_max + 1);
   localparam int dw = psum_bw * col;
   localparam logic [dw-1:0] most_neg = {col{{1'b1, {(psum_bw-1){1'b0}}}}};

   logic [dw-1:0] acc_mem [acc_depth];
   logic [dw-1:0] acc_rd, acc_sum, pool_next, lane_res, pool_max_reg;
   logic [pw-1:0] pool_cnt, pool_win_q, win_clamped, cnt_next;
   pool_state_t   pool_state;
   res_src_t      res_src;
   logic          accept, emit;

   assign in_ready    = !out_valid || out_ready;
   assign accept      = in_valid && in_ready;
   assign acc_rd      = acc_mem[addr];
   assign cnt_next    = pool_cnt + pw'(1);
   assign pool_busy   = (pool_cnt != '0);
   assign win_clamped = (pool_win == '0)           ? pw'(1) :
                        (pool_win > pw'(pool_max)) ? pw'(pool_max) : pool_win;

   for (genvar i = 0; i < col; i++) begin : g_lane
      sfp_lane #(.psum_bw(psum_bw)) u_lane (
         .in_val    (in_data[psum_bw*i +: psum_bw]),
         .acc_val   (acc_rd[psum_bw*i +: psum_bw]),
         .pool_val  (pool_max_reg[psum_bw*i +: psum_bw]),
         .relu_en   (relu_en),
         .res_src   (res_src),
         .acc_sum   (acc_sum[psum_bw*i +: psum_bw]),
         .pool_next (pool_next[psum_bw*i +: psum_bw]),
         .res       (lane_res[psum_bw*i +: psum_bw])
      );
   end

   always_comb begin
      emit    = 1'b0;
      res_src = SRC_IN;
      case (op)
         OP_BYPASS: emit = 1'b1;
         OP_READ: begin
            emit    = 1'b1;
            res_src = SRC_ACC;
         end
         OP_POOL: begin
            if (pool_state == POOL_IDLE) begin
               emit    = (win_clamped == pw'(1));
               res_src = SRC_IN;
            end else begin
               emit    = (cnt_next == pool_win_q);
               res_src = SRC_MAX;
            end
         end
         OP_FLUSH: begin
            emit    = (pool_state == POOL_FILL);
            res_src = SRC_POOL;
         end
         default: emit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < acc_depth; i++) acc_mem[i] <= '0;
      end else if (accept) begin
         if (op == OP_CLEAR)    acc_mem[addr] <= in_data;
         else if (op == OP_ACC) acc_mem[addr] <= acc_sum;
      end
   end

   // Other ops leave the pool state alone so accumulation can interleave with a window.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pool_state   <= POOL_IDLE;
         pool_cnt     <= '0;
         pool_win_q   <= pw'(1);
         pool_max_reg <= most_neg;
      end else if (accept) begin
         if (op == OP_POOL) begin
            if (pool_state == POOL_IDLE) begin
               pool_win_q   <= win_clamped;
               pool_max_reg <= in_data;
               if (win_clamped == pw'(1)) begin
                  pool_cnt <= '0;
               end else begin
                  pool_cnt   <= pw'(1);
                  pool_state <= POOL_FILL;
               end
            end else begin
               pool_max_reg <= pool_next;
               if (cnt_next == pool_win_q) begin
                  pool_cnt   <= '0;
                  pool_state <= POOL_IDLE;
               end else begin
                  pool_cnt <= cnt_next;
               end
            end
         end else if (op == OP_FLUSH && pool_state == POOL_FILL) begin
            pool_cnt   <= '0;
            pool_state <= POOL_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (accept && emit) begin
         out_valid <= 1'b1;
         out_data  <= lane_res;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sfp_multimode.sv
// tb/tb_sfp_multimode.sv - directed self-checking bench for sfp_multimode
module tb_sfp_multimode;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [2:0]   op;
   logic [3:0]   addr;
   logic         relu_en;
   logic [2:0]   pool_win;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         pool_busy;

   int vectors = 0;
   int miscompares = 0;

   localparam logic [127:0] mix_in   = {16'h0001, 16'h0002, 16'h8000, 16'h0003,
                                        16'hFFFF, 16'h0000, 16'h0007, 16'hFFFB};
   localparam logic [127:0] mix_relu = {16'h0001, 16'h0002, 16'h0000, 16'h0003,
                                        16'h0000, 16'h0000, 16'h0007, 16'h0000};

   sfp_multimode dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .addr      (addr),
      .relu_en   (relu_en),
      .pool_win  (pool_win),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .pool_busy (pool_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_op(input logic [2:0] o, input logic [3:0] a, input logic [127:0] d,
                        input logic r, input logic [2:0] w);
      int n = 0;
      @(negedge clk);
      op = o; addr = a; in_data = d; relu_en = r; pool_win = w; in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("accept_timeout", 128'(in_ready), 128'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; addr = 4'd0;
      relu_en = 1'b0; pool_win = 3'd1; in_data = '0;
      #12;
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_out_data", out_data, 128'd0);
      check("rst_pool_busy", 128'(pool_busy), 128'd0);
      check("rst_in_ready", 128'(in_ready), 128'd1);
      @(negedge clk);
      reset = 1'b1;

      do_op(3'd1, 4'd3, {8{16'h7FF0}}, 1'b0, 3'd1);
      do_op(3'd2, 4'd3, {8{16'h0020}}, 1'b0, 3'd1);
      do_op(3'd3, 4'd3, '0, 1'b0, 3'd1);
      check("sat_pos_valid", 128'(out_valid), 128'd1);
      check("sat_pos_data", out_data, {8{16'h7FFF}});
      do_op(3'd1, 4'd4, {8{16'h8010}}, 1'b0, 3'd1);
      do_op(3'd2, 4'd4, {8{16'hFFE0}}, 1'b0, 3'd1);
      do_op(3'd3, 4'd4, '0, 1'b0, 3'd1);
      check("sat_neg_data", out_data, {8{16'h8000}});

      do_op(3'd0, 4'd0, mix_in, 1'b1, 3'd1);
      check("relu_on", out_data, mix_relu);
      do_op(3'd0, 4'd0, mix_in, 1'b0, 3'd1);
      check("relu_off_valid", 128'(out_valid), 128'd1);
      check("relu_off_data", out_data, mix_in);
      @(posedge clk);
      #1;
      check("bypass_drained", 128'(out_valid), 128'd0);

      do_op(3'd4, 4'd0, 128'd4, 1'b0, 3'd3);
      check("pool1_busy", 128'(pool_busy), 128'd1);
      check("pool1_no_out", 128'(out_valid), 128'd0);
      do_op(3'd4, 4'd0, {112'd0, 16'hFFFE}, 1'b0, 3'd2);
      check("pool2_no_out", 128'(out_valid), 128'd0);
      do_op(3'd4, 4'd0, 128'd9, 1'b0, 3'd2);
      check("pool3_valid", 128'(out_valid), 128'd1);
      check("pool3_data", out_data, 128'd9);
      check("pool3_idle", 128'(pool_busy), 128'd0);

      do_op(3'd4, 4'd0, 128'd1, 1'b0, 3'd4);
      do_op(3'd4, 4'd0, 128'd6, 1'b0, 3'd4);
      do_op(3'd2, 4'd0, {8{16'd5}}, 1'b0, 3'd4);
      check("interleave_busy", 128'(pool_busy), 128'd1);
      check("interleave_no_out", 128'(out_valid), 128'd0);
      do_op(3'd5, 4'd0, {8{16'h7777}}, 1'b0, 3'd4);
      check("flush_valid", 128'(out_valid), 128'd1);
      check("flush_data", out_data, 128'd6);
      check("flush_idle", 128'(pool_busy), 128'd0);
      do_op(3'd3, 4'd0, '0, 1'b0, 3'd4);
      check("interleave_read", out_data, {8{16'd5}});
      do_op(3'd5, 4'd0, '0, 1'b0, 3'd4);
      check("flush_idle_nop", 128'(out_valid), 128'd0);

      out_ready = 1'b0;
      do_op(3'd0, 4'd0, {8{16'h1234}}, 1'b0, 3'd1);
      check("bp_valid", 128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      @(negedge clk);
      op = 3'd2; addr = 4'd1; in_data = {8{16'd3}}; in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("bp_hold_data", out_data, {8{16'h1234}});
      check("bp_still_stalled", 128'(in_ready), 128'd0);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_drained", 128'(out_valid), 128'd0);
      do_op(3'd3, 4'd1, '0, 1'b0, 3'd1);
      check("bp_single_acc", out_data, {8{16'd3}});

      do_op(3'd4, 4'd0, {8{16'd1}}, 1'b0, 3'd4);
      do_op(3'd4, 4'd0, {8{16'd2}}, 1'b0, 3'd4);
      check("rst_pre_busy", 128'(pool_busy), 128'd1);
      out_ready = 1'b0;
      do_op(3'd0, 4'd0, {8{16'hABCD}}, 1'b0, 3'd1);
      check("rst_pre_valid", 128'(out_valid), 128'd1);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_valid", 128'(out_valid), 128'd0);
      check("async_rst_busy", 128'(pool_busy), 128'd0);
      check("async_rst_data", out_data, 128'd0);
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      do_op(3'd3, 4'd3, '0, 1'b0, 3'd1);
      check("rst_acc_cleared", out_data, 128'd0);
      do_op(3'd4, 4'd0, {8{16'd12}}, 1'b0, 3'd0);
      check("win0_valid", 128'(out_valid), 128'd1);
      check("win0_data", out_data, {8{16'd12}});
      check("win0_idle", 128'(pool_busy), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/sfp_multimode.md
Name: sfp_multimode

Overview:
- Parametrised successor to the corelet special-function processor. It sits between the OFIFO read port and the output SRAM write path.
- Provides per-column signed accumulation into an addressable accumulator bank, optional ReLU, and max-pooling over a runtime-programmable window.
- Adds ready/valid backpressure on the output.
- One registered output stage; all lanes operate in lockstep.

Parameters:
- psum_bw, 16, signed width of each lane.
- col, 8, number of lanes (PE array columns).
- acc_depth, 16, accumulator entries per lane (power of 2).
- pool_max, 4, largest supported pool window.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  op/data presented this cycle.
- in_ready  output  1  high when the block can accept an op: !out_valid || out_ready.
- op  input  3  operation: 0 BYPASS, 1 CLEAR, 2 ACC, 3 READ, 4 POOL, 5 POOL_FLUSH; values 6-7 are NOPs.
- addr  input  $clog2(acc_depth)  accumulator entry.
- relu_en  input  1  clamp negative lanes to 0 on output.
- pool_win  input  $clog2(pool_max+1)  pool window length.
- in_data  input  psum_bw*col  lane i at [psum_bw*(i+1)-1 : psum_bw*i].
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  psum_bw*col  result lanes.
- pool_busy  output  1  a pool window is partially filled (pool count > 0).

Behaviour:
- Transfer: an op is accepted when in_valid && in_ready. Ops not accepted have no effect.
- Output register: out_data and out_valid load 1 cycle after an accepted output-producing op, and hold until out_valid && out_ready. The register may load a new result on the same cycle the old one drains.
- Reset (asynchronous assert, active-low):
  - out_valid=0, out_data=0.
  - All accumulator entries = 0.
  - pool_cnt=0, pool_max_reg = most negative value per lane, pool_busy=0, latched window = 1.
- BYPASS: out = f(in_data), where f = per-lane ReLU if relu_en, else identity.
- CLEAR: acc[addr] <= in_data. No output.
- ACC: acc[addr] <= sat(acc[addr] + in_data) per lane. No output.
  - sat: the signed sum is computed at psum_bw+1 bits, then clamped to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- READ: out = f(acc[addr]). An entry written by an accepted op in cycle N is seen by a READ in cycle N+1 (write-before-read across cycles; no bypass needed within the same cycle since only one op is accepted per cycle).
- POOL (state machine IDLE/FILL):
  - In IDLE, an accepted POOL latches win = clamp(pool_win): 0 maps to 1, values above pool_max map to pool_max. It loads pool_max_reg = in_data and sets cnt=1.
  - In FILL, an accepted POOL updates pool_max_reg = per-lane signed max(pool_max_reg, in_data) and increments cnt. The pool_win input is ignored until the window completes.
  - When cnt reaches win (including win=1 on the first sample): out = f(final max), cnt returns to 0, state returns to IDLE. The result is issued in the same accept cycle, so it appears 1 cycle later.
- POOL_FLUSH:
  - In FILL: outputs f(pool_max_reg) and returns to IDLE.
  - In IDLE: acts as a NOP with no output.
  - Its in_data is ignored.
- Other ops during FILL leave the pool state untouched, so accumulation can be interleaved with pooling.
- Max comparison is signed. Ties keep the stored value.
- ReLU is applied only at output, never to stored accumulator or pool state.
- in_ready stays low while out_valid && !out_ready. This stalls every op, including non-output ops, which keeps ordering simple.
- Reset asserted mid-window discards the partial max. Reset asserted with out_valid high drops the pending result.

Decomposition:
- Package sfp_pkg:
  - op encoding localparams: OP_BYPASS=0, OP_CLEAR=1, OP_ACC=2, OP_READ=3, OP_POOL=4, OP_FLUSH=5.
  - Pool state encoding.
  - Functions sat_add(a,b) and relu(x).
- One sub-module, sfp_lane: per-lane saturating adder, signed max, and ReLU mux, generated col times. The top level keeps the accumulator bank, pool FSM/counter and output handshake.

Test Plan:
- Saturation: reset; CLEAR addr 3 with all lanes 0x7FF0; ACC addr 3 with 0x0020; READ addr 3, relu_en=0 -> every lane 0x7FFF. Repeat with -0x7FF0 + -0x0020 -> 0x8000.
- ReLU: BYPASS lanes {-5, 7, 0, -1, 3, 0x8000, 2, 1} with relu_en=1 -> {0, 7, 0, 0, 3, 0, 2, 1}. With relu_en=0 -> unchanged, out_valid exactly 1 cycle after accept.
- Pool window: pool_win=3; POOL lane0 samples {4, -2, 9}; out_valid only after the 3rd sample, lane0 = 9. Change pool_win to 2 after the 1st sample -> still waits for 3 samples.
- Interleave and flush: pool_win=4; POOL {1, 6}, then ACC addr 0 += 5, then POOL_FLUSH -> out lane0 = 6, pool_busy goes 0. Then READ addr 0 -> 5.
- Backpressure: hold out_ready=0 after one BYPASS -> in_ready=0 and the next ACC is not applied. Raise out_ready -> first result drains, ACC proceeds, and READ confirms a single increment.
- Reset: drop reset mid-window (cnt=2) -> out_valid=0, pool_busy=0 immediately (asynchronous), READ addr 3 -> 0. pool_win=0 then POOL value 12 -> output 12 after 1 sample.
